// File: rtl/vm_multi.sv
// Parametrised vending-machine controller: per-item prices and stock, cancel/refund,
// coin rejection and serial $10 change return. Optional VM_RESTOCK_EN adds a restock input.
module vm_multi #(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned VALUE_W    = 8,
  parameter logic [NUM_ITEMS*VALUE_W-1:0] PRICES = {8'd40, 8'd30, 8'd20, 8'd10},
  parameter int unsigned STOCK_INIT = 3,
  localparam int unsigned ITEM_W    = $clog2(NUM_ITEMS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef VM_RESTOCK_EN
  input  logic                 restock,
`endif
  input  logic [ITEM_W-1:0]    item,
  input  logic                 sel,
  input  logic                 cancel,
  input  logic                 dollar_10,
  input  logic                 dollar_50,
  output logic [VALUE_W-1:0]   value,
  output logic [ITEM_W-1:0]    item_rels,
  output logic                 change_return,
  output logic                 coin_reject,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 busy
);

  localparam int unsigned STOCK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;
  localparam int unsigned SUM_W   = VALUE_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_SELECTED, S_DISPENSE, S_CHANGE} state_e;

  state_e               state_q, state_d;
  logic [VALUE_W-1:0]   credit_q, credit_d;
  logic [ITEM_W-1:0]    sel_item_q, sel_item_d;
  logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
  logic [ITEM_W-1:0]    item_rels_q, item_rels_d;
  logic                 change_return_q, change_return_d;
  logic                 coin_reject_q, coin_reject_d;
  logic                 busy_q, busy_d;

  logic                 coin_any;
  logic [SUM_W-1:0]     add;
  logic [SUM_W-1:0]     sum;
  logic                 overflow;
  logic [VALUE_W-1:0]   price;
  logic                 sel_valid;
  logic                 do_change;
  logic [VALUE_W-1:0]   credit_base;

  // Coin arithmetic, price lookup and selection validity
  always_comb begin
    coin_any = dollar_10 | dollar_50;
    add = '0;
    if (dollar_10) add = add + SUM_W'(10);
    if (dollar_50) add = add + SUM_W'(50);
    sum       = SUM_W'(credit_q) + add;
    overflow  = sum[VALUE_W];
    price     = '0;
    sel_valid = 1'b0;
    for (int k = 0; k < int'(NUM_ITEMS); k++) begin
      if (sel_item_q == ITEM_W'(k + 1)) price = PRICES[k*VALUE_W +: VALUE_W];
      if (sel && item == ITEM_W'(k + 1) && stock_q[k] != '0) sel_valid = 1'b1;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    sel_item_d      = sel_item_q;
    stock_d         = stock_q;
    item_rels_d     = '0;
    change_return_d = 1'b0;
    coin_reject_d   = 1'b0;
    do_change       = 1'b0;
    credit_base     = credit_q;

    case (state_q)
      S_IDLE, S_SELECTED: begin
        if (cancel) begin
          coin_reject_d = coin_any;
          sel_item_d    = '0;
          if (credit_q != '0) do_change = 1'b1;
          else state_d = S_IDLE;
        end else begin
          if (coin_any) begin
            if (overflow) coin_reject_d = 1'b1;
            else credit_base = sum[VALUE_W-1:0];
          end
          credit_d = credit_base;
          if (state_q == S_SELECTED && credit_q >= price) begin
            state_d     = S_DISPENSE;
            credit_d    = credit_base - price;
            item_rels_d = sel_item_q;
            for (int k = 0; k < int'(NUM_ITEMS); k++) begin
              if (sel_item_q == ITEM_W'(k + 1)) stock_d[k] = stock_q[k] - STOCK_W'(1);
            end
          end else if (sel_valid) begin
            state_d    = S_SELECTED;
            sel_item_d = item;
          end
`ifdef VM_RESTOCK_EN
          if (state_q == S_IDLE && restock) begin
            for (int k = 0; k < int'(NUM_ITEMS); k++) stock_d[k] = STOCK_W'(STOCK_INIT);
          end
`endif
        end
      end
      S_DISPENSE: begin
        coin_reject_d = coin_any;
        sel_item_d    = '0;
        if (credit_q != '0) do_change = 1'b1;
        else state_d = S_IDLE;
      end
      default: begin
        coin_reject_d = coin_any;
        do_change     = 1'b1;
      end
    endcase

    // Each change step returns one $10 unit; the step that empties credit lands in IDLE
    if (do_change) begin
      credit_d        = credit_q - VALUE_W'(10);
      change_return_d = 1'b1;
      state_d         = (credit_q == VALUE_W'(10)) ? S_IDLE : S_CHANGE;
    end

    busy_d = (state_d == S_DISPENSE) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      credit_q        <= '0;
      sel_item_q      <= '0;
      item_rels_q     <= '0;
      change_return_q <= 1'b0;
      coin_reject_q   <= 1'b0;
      busy_q          <= 1'b0;
      for (int k = 0; k < int'(NUM_ITEMS); k++) stock_q[k] <= STOCK_W'(STOCK_INIT);
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      sel_item_q      <= sel_item_d;
      item_rels_q     <= item_rels_d;
      change_return_q <= change_return_d;
      coin_reject_q   <= coin_reject_d;
      busy_q          <= busy_d;
      for (int k = 0; k < int'(NUM_ITEMS); k++) stock_q[k] <= stock_d[k];
    end
  end

  always_comb begin
    for (int k = 0; k < int'(NUM_ITEMS); k++) sold_out[k] = (stock_q[k] == '0);
  end

  assign value         = credit_q;
  assign item_rels     = item_rels_q;
  assign change_return = change_return_q;
  assign coin_reject   = coin_reject_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_vm_multi.sv
// Scoreboard bench for vm_multi: stimulus queues expected release/change/reject events,
// a negedge monitor pops and compares them; direct checks cover credit, flags and reset.
module tb_vm_multi;

  typedef struct packed {
    logic [2:0] rels;
    logic       cr;
    logic       rej;
    logic [7:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       restock_i = 1'b0;
  logic [2:0] item = '0;
  logic       sel = 1'b0;
  logic       cancel = 1'b0;
  logic       dollar_10 = 1'b0;
  logic       dollar_50 = 1'b0;
  logic [7:0] value;
  logic [2:0] item_rels;
  logic       change_return;
  logic       coin_reject;
  logic [3:0] sold_out;
  logic       busy;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  vm_multi dut (
    .clk(clk),
    .rst(rst),
`ifdef VM_RESTOCK_EN
    .restock(restock_i),
`endif
    .item(item),
    .sel(sel),
    .cancel(cancel),
    .dollar_10(dollar_10),
    .dollar_50(dollar_50),
    .value(value),
    .item_rels(item_rels),
    .change_return(change_return),
    .coin_reject(coin_reject),
    .sold_out(sold_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  task automatic push(input logic [2:0] r, input logic c, input logic j, input logic [7:0] v);
    ev_t e;
    e.rels = r; e.cr = c; e.rej = j; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] it, input logic s, input logic c,
                       input logic d10, input logic d50, input logic rs);
    item = it; sel = s; cancel = c; dollar_10 = d10; dollar_50 = d50; restock_i = rs;
    @(posedge clk); #1;
    item = '0; sel = 1'b0; cancel = 1'b0; dollar_10 = 1'b0; dollar_50 = 1'b0; restock_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: any release, change or reject pulse must match the next queued event
  always @(negedge clk) begin
    if (rst && (item_rels != '0 || change_return || coin_reject)) begin
      ev_t got, e;
      got.rels = item_rels; got.cr = change_return; got.rej = coin_reject; got.val = value;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got rels=%0d cr=%0b rej=%0b value=%0d, none expected",
                 got.rels, got.cr, got.rej, got.val);
      end else begin
        e = exp_q.pop_front();
        if (got != e) begin
          errors++;
          $display("FAIL event: got rels=%0d cr=%0b rej=%0b value=%0d expected rels=%0d cr=%0b rej=%0b value=%0d",
                   got.rels, got.cr, got.rej, got.val, e.rels, e.cr, e.rej, e.val);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_value", value, 0);
    chk("reset_item_rels", item_rels, 0);
    chk("reset_change", change_return, 0);
    chk("reset_reject", coin_reject, 0);
    chk("reset_sold_out", sold_out, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b1;
    idle(1);

    // Buy item 2 ($20) with $60, receive $40 change
    drive(3'd2, 1, 0, 0, 0, 0);
    drive(3'd0, 0, 0, 1, 0, 0);
    chk("t1_value10", value, 10);
    drive(3'd0, 0, 0, 0, 1, 0);
    chk("t1_value60", value, 60);
    push(3'd2, 0, 0, 8'd40);
    for (int v = 30; v >= 0; v -= 10) push(3'd0, 1, 0, 8'(v));
    idle(1);
    chk("t1_item_rels", item_rels, 2);
    chk("t1_value40", value, 40);
    chk("t1_busy", busy, 1);
    idle(4);
    chk("t1_value_end", value, 0);
    idle(1);
    chk("t1_change_done", change_return, 0);
    chk("t1_busy_done", busy, 0);

    // Select item 4, insert $20, cancel
    drive(3'd4, 1, 0, 0, 0, 0);
    drive(3'd0, 0, 0, 1, 0, 0);
    drive(3'd0, 0, 0, 1, 0, 0);
    chk("t2_value20", value, 20);
    push(3'd0, 1, 0, 8'd10);
    push(3'd0, 1, 0, 8'd0);
    drive(3'd0, 0, 1, 0, 0, 0);
    chk("t2_cancel_value", value, 10);
    idle(2);
    chk("t2_value0", value, 0);
    chk("t2_sold_out", sold_out, 0);

    // Exhaust item 1 with exact $10 purchases
    for (int n = 0; n < 3; n++) begin
      push(3'd1, 0, 0, 8'd0);
      drive(3'd1, 1, 0, 1, 0, 0);
      chk("t3_value10", value, 10);
      idle(2);
    end
    chk("t3_sold_out", sold_out, 4'b0001);
    drive(3'd1, 1, 0, 0, 0, 0);
    drive(3'd0, 0, 0, 1, 0, 0);
    idle(2);
    chk("t3_no_dispense_value", value, 10);
    push(3'd0, 1, 0, 8'd0);
    drive(3'd0, 0, 1, 0, 0, 0);
    idle(1);

    // Overflow rejection at 250, then rejection during change
    for (int n = 1; n <= 5; n++) begin
      drive(3'd0, 0, 0, 0, 1, 0);
      chk("t4_value_build", value, n * 50);
    end
    push(3'd0, 0, 1, 8'd250);
    drive(3'd0, 0, 0, 1, 0, 0);
    chk("t4_overflow_reject", coin_reject, 1);
    chk("t4_overflow_value", value, 250);
    for (int v = 240; v >= 0; v -= 10) push(3'd0, 1, (v == 230), 8'(v));
    drive(3'd0, 0, 1, 0, 0, 0);
    drive(3'd0, 0, 0, 1, 0, 0);
    chk("t4_change_reject", coin_reject, 1);
    idle(23);
    chk("t4_value0", value, 0);

    // Double coin, invalid item codes, then item 3
    drive(3'd0, 0, 0, 1, 1, 0);
    chk("t5_value60", value, 60);
    drive(3'd0, 1, 0, 0, 0, 0);
    idle(1);
    drive(3'd5, 1, 0, 0, 0, 0);
    idle(2);
    chk("t5_invalid_value", value, 60);
    chk("t5_invalid_busy", busy, 0);
    push(3'd3, 0, 0, 8'd30);
    for (int v = 20; v >= 0; v -= 10) push(3'd0, 1, 0, 8'(v));
    drive(3'd3, 1, 0, 0, 0, 0);
    idle(4);
    chk("t5_value0", value, 0);
    idle(1);

    // Reset in the middle of change return
    push(3'd2, 0, 0, 8'd30);
    drive(3'd2, 1, 0, 0, 1, 0);
    chk("t6_value50", value, 50);
    idle(2);
    chk("t6_busy_change", busy, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_value", value, 0);
    chk("t6_rst_change", change_return, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_item_rels", item_rels, 0);
    chk("t6_rst_sold_out", sold_out, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);

`ifdef VM_RESTOCK_EN
    for (int n = 0; n < 3; n++) begin
      push(3'd2, 0, 0, 8'd0);
      drive(3'd2, 1, 0, 1, 0, 0);
      drive(3'd0, 0, 0, 1, 0, 0);
      idle(2);
    end
    chk("t7_depleted", sold_out, 4'b0010);
    drive(3'd0, 0, 0, 0, 0, 1);
    chk("t7_restocked", sold_out, 0);
`endif

    idle(3);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vm_multi.md
# vm_multi

Parametrised vending-machine controller: successor of the fixed three-item, 8-bit VM, generalised to NUM_ITEMS products with per-item prices and per-item stock counters. Adds cancel/refund, sold-out flags, coin rejection on overflow or while busy, and serial change return, one $10 unit per cycle. Sits between the coin/keypad front end and the dispenser/change-hopper drivers.

## Interface
- NUM_ITEMS, 4, number of products; item codes 1..NUM_ITEMS, 0 = none
- VALUE_W, 8, credit and price width
- PRICES, {8'd40,8'd30,8'd20,8'd10}, packed prices; item k (1-based) at [(k-1)*VALUE_W +: VALUE_W]; each a nonzero multiple of 10
- STOCK_INIT, 3, units per item after reset
- ITEM_W (localparam) = $clog2(NUM_ITEMS+1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- item  in  ITEM_W  item code for selection
- sel  in  1  select strobe, sampled with item
- cancel  in  1  abort, refund credit
- dollar_10  in  1  $10 coin, one per asserted cycle
- dollar_50  in  1  $50 coin, one per asserted cycle
- value  out  VALUE_W  current credit
- item_rels  out  ITEM_W  released item code, 1-cycle pulse, else 0
- change_return  out  1  one $10 returned per high cycle
- coin_reject  out  1  a coin sampled last cycle was refused
- sold_out  out  NUM_ITEMS  bit k-1 = item k stock is 0
- busy  out  1  high in DISPENSE/CHANGE

## Operation
- States: IDLE, SELECTED, DISPENSE, CHANGE. Regs: credit, sel_item, stock[k].
- Coins are accepted in IDLE and SELECTED. Add = 10*dollar_10 + 50*dollar_50; both in one cycle = +60.
- Overflow: if credit + add > 2^VALUE_W - 1, the whole add is refused. coin_reject goes high next cycle and credit is unchanged.
- Coins in DISPENSE/CHANGE are always refused (coin_reject).
- Valid sel: item in 1..NUM_ITEMS and not sold out. IDLE -> SELECTED, sel_item <= item. In SELECTED, a valid sel replaces sel_item. Invalid sel is ignored.
- SELECTED with registered credit >= price(sel_item) -> DISPENSE at that edge. Same edge: credit <= credit - price + accepted add; item_rels <= sel_item; stock[sel_item] -= 1.
- DISPENSE (one cycle) -> CHANGE if credit > 0, else IDLE. sel_item cleared.
- CHANGE: each cycle change_return = 1 and credit -= 10. Leaves to IDLE on the edge where credit reaches 0.
- cancel in IDLE/SELECTED has highest priority: sel_item cleared, that cycle's coins refused. Goes to CHANGE if credit > 0, else IDLE. cancel in DISPENSE/CHANGE is ignored.
- Sel and coins in the same IDLE cycle: both take effect. The dispense check happens on the following cycle.
- sold_out[k-1] = (stock[k] == 0), combinational from the regs.

## Timing
- All outputs except sold_out are registered; inputs are sampled on the rising edge and effects show 1 cycle later.
- Coin -> value update: 1 cycle. Credit sufficient -> item_rels: 1 cycle after the credit is visible on value.
- item_rels is high exactly 1 cycle. Change of C takes C/10 consecutive change_return cycles, starting the cycle after item_rels.
- Reset (any time, mid-dispense/change included): state IDLE, credit 0, value 0, item_rels 0, change_return 0, coin_reject 0, busy 0, all stock = STOCK_INIT, sold_out all 0. In-flight credit is lost.

## Configuration
- VM_RESTOCK_EN defined: adds input port restock (1 bit). restock high in IDLE reloads every stock to STOCK_INIT at that edge. It is ignored in other states.
- Undefined: no restock port; stock reloads only on reset.

## Test plan
- Defaults, reset, sel item 2, dollar_10 then dollar_50 -> value 10, 60. Then item_rels=2 for one cycle with value 40. Then change_return for 4 cycles with value 30, 20, 10, 0. Then IDLE.
- sel item 4, dollar_10 x2, cancel -> no item_rels; 2 change_return cycles; value returns to 0; stock[4] still 3.
- Buy item 1 three times with exact $10 -> after the third dispense, sold_out[0]=1. A fourth sel item 1 is ignored and a coin then does not dispense.
- With credit 250, dollar_10 -> coin_reject=1 next cycle, value stays 250. dollar_10 during CHANGE -> coin_reject=1.
- dollar_10 and dollar_50 in the same cycle in IDLE -> value 60. sel item 3 with item 0 / item 5 (NUM_ITEMS=4) -> ignored.
- Assert rst mid-CHANGE -> all outputs reset immediately, stock = 3. With VM_RESTOCK_EN: deplete item 2, restock in IDLE -> sold_out[1]=0.
